// File: rtl/huff_phase_sched_if.sv
// Handshake bundle between the Huffman phase scheduler and the rest of the coder.
// The slave modport is the scheduler's view; master is the surrounding datapath/bench.
interface huff_phase_sched_if #(
  parameter int RND_W = 3
);
  logic             gray_valid;
  logic             sort_ack;
  logic             cnt_valid;
  logic             sort_req;
  logic             merge_en;
  logic             split_en;
  logic [RND_W-1:0] round;
  logic             code_valid;
  logic             busy;
  logic             err;

  modport master (
    output gray_valid, sort_ack,
    input  cnt_valid, sort_req, merge_en, split_en, round, code_valid, busy, err
  );

  modport slave (
    input  gray_valid, sort_ack,
    output cnt_valid, sort_req, merge_en, split_en, round, code_valid, busy, err
  );
endinterface

// File: rtl/huff_phase_sched.sv
// Phase scheduler for the Huffman gray-level coder: count -> sort/merge rounds -> split -> code out.
// Optional macro SORT_WDT_EN adds a sort watchdog that aborts to an ERR state after WDT_LIMIT cycles.
module huff_phase_sched #(
  parameter int NSYM      = 6,
  parameter int RND_W     = 3,
  parameter int WDT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  huff_phase_sched_if.slave     bus
);

  if (((1 << RND_W) < NSYM) || (NSYM < 2) || (WDT_LIMIT < 2)) begin : g_param_chk
    $error("huff_phase_sched: invalid NSYM/RND_W/WDT_LIMIT combination");
  end

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NSYM - 2);

`ifdef SORT_WDT_EN
  typedef enum logic [2:0] {IDLE, COUNT, CNTV, SORT, MERGE, SPLIT, CODEV, ERR} state_t;
  localparam int             WDT_W    = $clog2(WDT_LIMIT);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             err_q, err_d;
`else
  typedef enum logic [2:0] {IDLE, COUNT, CNTV, SORT, MERGE, SPLIT, CODEV} state_t;
`endif

  state_t           state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             sort_req_q, sort_req_d;
  logic             merge_en_q, merge_en_d;
  logic             split_en_q, split_en_d;
  logic             code_valid_q, code_valid_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
`ifdef SORT_WDT_EN
    wdt_d   = wdt_q;
`endif
    case (state_q)
      IDLE:  if (bus.gray_valid) state_d = COUNT;
      COUNT: if (!bus.gray_valid) state_d = CNTV;
      CNTV: begin
        round_d = '0;
        state_d = SORT;
`ifdef SORT_WDT_EN
        wdt_d   = '0;
`endif
      end
      SORT: begin
        // An ack arriving on the same cycle the watchdog expires still wins.
        if (bus.sort_ack) begin
          state_d = MERGE;
        end
`ifdef SORT_WDT_EN
        else if (wdt_q == WDT_LAST) begin
          state_d = ERR;
          round_d = '0;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
`endif
      end
      MERGE: begin
        if (round_q == LAST_RND) begin
          state_d = SPLIT;
        end else begin
          round_d = round_q + RND_W'(1);
          state_d = SORT;
`ifdef SORT_WDT_EN
          wdt_d   = '0;
`endif
        end
      end
      SPLIT: begin
        if (round_q == '0) state_d = CODEV;
        else               round_d = round_q - RND_W'(1);
      end
      CODEV: begin
        round_d = '0;
        state_d = IDLE;
      end
`ifdef SORT_WDT_EN
      ERR:     state_d = IDLE;
`endif
      default: begin
        round_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cnt_valid_d  = (state_d == CNTV);
    sort_req_d   = (state_d == SORT);
    merge_en_d   = (state_d == MERGE);
    split_en_d   = (state_d == SPLIT);
    code_valid_d = (state_d == CODEV);
    busy_d       = (state_d != IDLE);
`ifdef SORT_WDT_EN
    err_d        = (state_d == ERR);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      round_q      <= '0;
      cnt_valid_q  <= 1'b0;
      sort_req_q   <= 1'b0;
      merge_en_q   <= 1'b0;
      split_en_q   <= 1'b0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SORT_WDT_EN
      wdt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cnt_valid_q  <= cnt_valid_d;
      sort_req_q   <= sort_req_d;
      merge_en_q   <= merge_en_d;
      split_en_q   <= split_en_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
`ifdef SORT_WDT_EN
      wdt_q        <= wdt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.cnt_valid  = cnt_valid_q;
  assign bus.sort_req   = sort_req_q;
  assign bus.merge_en   = merge_en_q;
  assign bus.split_en   = split_en_q;
  assign bus.round      = round_q;
  assign bus.code_valid = code_valid_q;
  assign bus.busy       = busy_q;
`ifdef SORT_WDT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_huff_phase_sched.sv
// Bench for huff_phase_sched: frames are walked phase by phase from the scheduling rules,
// with random count lengths, random sort_ack delays and random noise on ignored inputs.
module tb_huff_phase_sched;
  localparam int NSYM      = 6;
  localparam int RND_W     = 3;
  localparam int WDT_LIMIT = 16;
  localparam int VW        = RND_W + 7;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   wait_tab [NSYM-1];

  huff_phase_sched_if #(.RND_W(RND_W)) bus ();

  huff_phase_sched #(.NSYM(NSYM), .RND_W(RND_W), .WDT_LIMIT(WDT_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  // {cnt_valid, sort_req, merge_en, split_en, round, code_valid, busy, err}
  function automatic logic [VW-1:0] ev(bit c, bit rq, bit m, bit s, int rnd, bit cv, bit b, bit e);
    logic [RND_W-1:0] r;
    r = RND_W'(rnd);
    return {c, rq, m, s, r, cv, b, e};
  endfunction

  task automatic chk(string tag, logic [VW-1:0] exp);
    logic [VW-1:0] obs;
    obs = {bus.cnt_valid, bus.sort_req, bus.merge_en, bus.split_en, bus.round,
           bus.code_valid, bus.busy, bus.err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (cnt,req,mrg,spl,round,code,busy,err)", tag, obs, exp);
    end
  endtask

  task automatic step(bit gv, bit ack);
    bus.gray_valid = gv;
    bus.sort_ack   = ack;
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One frame from IDLE. wait_tab[r] = cycles sort_ack is withheld in round r.
  // abort_r >= 0 returns right after the MERGE of that round.
  task automatic run_frame(int ncount, int abort_r);
    int lat;
    int total_wait;
    total_wait = 0;
    step(1'b1, rb());
    chk("count_entry", ev(0,0,0,0,0,0,1,0));
    for (int i = 1; i < ncount; i++) begin
      step(1'b1, rb());
      chk("count_hold", ev(0,0,0,0,0,0,1,0));
    end
    step(1'b0, rb());
    lat = 1;
    chk("cnt_valid", ev(1,0,0,0,0,0,1,0));
    for (int r = 0; r <= NSYM-2; r++) begin
      step(rb(), rb());
      lat++;
      chk("sort_entry", ev(0,1,0,0,r,0,1,0));
      for (int w = 0; w < wait_tab[r]; w++) begin
        step(rb(), 1'b0);
        lat++;
        total_wait++;
        chk("sort_wait", ev(0,1,0,0,r,0,1,0));
      end
      step(rb(), 1'b1);
      lat++;
      chk("merge", ev(0,0,1,0,r,0,1,0));
      if (r == abort_r) return;
    end
    for (int rr = NSYM-2; rr >= 0; rr--) begin
      step(rb(), rb());
      lat++;
      chk("split", ev(0,0,0,1,rr,0,1,0));
    end
    step(rb(), rb());
    lat++;
    chk("code_valid", ev(0,0,0,0,0,1,1,0));
    checks++;
    assert (lat === 17 + total_wait) else begin
      errors++;
      $error("FAIL latency observed=%0d expected=%0d", lat, 17 + total_wait);
    end
    step(rb(), rb());
    chk("back_to_idle", ev(0,0,0,0,0,0,0,0));
  endtask

  initial begin
    bus.gray_valid = 1'b0;
    bus.sort_ack   = 1'b0;
    reset = 1'b1;
    #2;
    chk("reset_state", ev(0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 1'b1);
    chk("idle_no_gv", ev(0,0,0,0,0,0,0,0));

    // Directed: 4 count cycles, ack immediate in every round.
    foreach (wait_tab[i]) wait_tab[i] = 0;
    run_frame(4, -1);

    // Directed: ack withheld 3 cycles in round 2.
    wait_tab[2] = 3;
    run_frame(4, -1);

    // Reset asynchronously in the middle of MERGE round 3.
    foreach (wait_tab[i]) wait_tab[i] = $urandom_range(0, 2);
    run_frame(2, 3);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_merge", ev(0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    chk("reset_held", ev(0,0,0,0,0,0,0,0));
    reset = 1'b0;
    step(1'b0, 1'b1);
    chk("idle_after_reset", ev(0,0,0,0,0,0,0,0));
    foreach (wait_tab[i]) wait_tab[i] = 0;
    run_frame(3, -1);

    // Randomised back-to-back frames.
    for (int f = 0; f < 8; f++) begin
      foreach (wait_tab[i]) wait_tab[i] = $urandom_range(0, 4);
      run_frame($urandom_range(1, 5), -1);
    end

`ifdef SORT_WDT_EN
    // Ack never arrives: 16 SORT cycles, then one ERR cycle, then IDLE.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("wdt_cntv", ev(1,0,0,0,0,0,1,0));
    step(1'b0, 1'b0);
    chk("wdt_sort1", ev(0,1,0,0,0,0,1,0));
    for (int k = 2; k <= WDT_LIMIT; k++) begin
      step(1'b0, 1'b0);
      chk("wdt_sort_wait", ev(0,1,0,0,0,0,1,0));
    end
    step(1'b0, 1'b0);
    chk("wdt_err", ev(0,0,0,0,0,0,1,1));
    step(1'b0, 1'b0);
    chk("wdt_idle", ev(0,0,0,0,0,0,0,0));

    // Ack on the limit cycle wins.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 2; k <= WDT_LIMIT; k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("wdt_ack_wins", ev(0,0,1,0,0,0,1,0));
    reset = 1'b1;
    #1;
    chk("wdt_reset", ev(0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
